// File: rtl/isolde_xif_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : isolde_xif_pkg
//  Description : Shared XIF types for the ISOLDE coprocessor interface.
//                Holds the result-channel payload struct, its default field
//                widths and a helper that gives the payload width for any
//                id / register-file-write width.
//  Revision    : 1.0 - initial release
// ============================================================================
package isolde_xif_pkg;

    localparam int XLEN          = 32;
    localparam int XIF_ID_WIDTH  = 4;
    localparam int XIF_RFW_WIDTH = 32;

    // Field order matches the interface result struct.
    typedef struct packed {
        logic [XIF_ID_WIDTH-1:0]     id;
        logic [XIF_RFW_WIDTH-1:0]    data;
        logic [4:0]                  rd;
        logic [XIF_RFW_WIDTH/32-1:0] we;
        logic [5:0]                  ecsdata;
        logic [2:0]                  ecswe;
        logic                        exc;
        logic [5:0]                  exccode;
        logic                        err;
        logic                        dbg;
    } x_result_t;

    // Packed width of a result for arbitrary id / rfw widths; equals
    // $bits(x_result_t) for the package defaults.
    function automatic int x_result_width(input int id_w, input int rfw_w);
        return id_w + rfw_w + 5 + rfw_w / 32 + 6 + 3 + 1 + 6 + 1 + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/isolde_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : isolde_rr_arbiter
//  Description : Combinational round-robin selector. Returns the first
//                asserted request found scanning ptr_i, ptr_i+1, ... modulo N.
//  Ports       : req_i         - request vector
//                ptr_i         - highest-priority index
//                grant_valid_o - some request is asserted
//                grant_idx_o   - index of the selected request
//  Revision    : 1.0 - initial release
// ============================================================================
module isolde_rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             grant_valid_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    int idx;

    // Scan from the farthest offset down to offset 0 so the closest
    // requester to the pointer overwrites any earlier hit.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        idx           = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = idx[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/isolde_xif_result_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : isolde_xif_result_arbiter
//  Description : Shares the CPU XIF result channel among N_COPROC
//                coprocessors. A round-robin grant loads a one-entry output
//                register that feeds the CPU with one cycle of latency and
//                full throughput.
//  Ports       : clk_i, rst_i              - clock, sync active-high reset
//                coproc_result_valid_i/_o  - per-coprocessor handshake
//                coproc_result_i           - per-coprocessor payload
//                cpu_result_valid_o/_ready_i - CPU-side handshake
//                cpu_result_o              - registered payload
//                cpu_result_src_o          - producer of cpu_result_o
//  Revision    : 1.0 - initial release
// ============================================================================
module isolde_xif_result_arbiter
    import isolde_xif_pkg::*;
#(
    parameter  int N_COPROC    = 4,
    parameter  int X_ID_WIDTH  = XIF_ID_WIDTH,
    parameter  int X_RFW_WIDTH = XIF_RFW_WIDTH,
    localparam int RES_W       = x_result_width(X_ID_WIDTH, X_RFW_WIDTH),
    localparam int SRC_W       = (N_COPROC > 1) ? $clog2(N_COPROC) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [N_COPROC-1:0]            coproc_result_valid_i,
    output logic [N_COPROC-1:0]            coproc_result_ready_o,
    input  logic [N_COPROC-1:0][RES_W-1:0] coproc_result_i,
    output logic                           cpu_result_valid_o,
    input  logic                           cpu_result_ready_i,
    output logic [RES_W-1:0]               cpu_result_o,
    output logic [SRC_W-1:0]               cpu_result_src_o
);

    localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(N_COPROC - 1);

    logic             out_valid_q,  out_valid_d;
    logic [RES_W-1:0] out_result_q, out_result_d;
    logic [SRC_W-1:0] out_src_q,    out_src_d;
    logic [SRC_W-1:0] rr_ptr_q,     rr_ptr_d;

    logic             grant_valid;
    logic [SRC_W-1:0] grant_idx;
    logic             slot_free;
    logic             handshake;

    isolde_rr_arbiter #(
        .N (N_COPROC)
    ) u_rr_arbiter (
        .req_i         (coproc_result_valid_i),
        .ptr_i         (rr_ptr_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    always_comb begin
        // The register can take a new result if empty or being drained now.
        slot_free    = !out_valid_q || cpu_result_ready_i;
        handshake    = grant_valid && slot_free && !rst_i;

        coproc_result_ready_o = '0;
        if (handshake) begin
            coproc_result_ready_o[grant_idx] = 1'b1;
        end

        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_src_d    = out_src_q;
        rr_ptr_d     = rr_ptr_q;

        if (handshake) begin
            out_valid_d  = 1'b1;
            out_result_d = coproc_result_i[grant_idx];
            out_src_d    = grant_idx;
            // Explicit wrap keeps non-power-of-two N correct.
            rr_ptr_d     = (grant_idx == LAST_IDX) ? '0 : grant_idx + SRC_W'(1);
        end else if (cpu_result_ready_i) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_src_q    <= '0;
            rr_ptr_q     <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_src_q    <= out_src_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign cpu_result_valid_o = out_valid_q;
    assign cpu_result_o       = out_result_q;
    assign cpu_result_src_o   = out_src_q;

endmodule
`default_nettype wire

// File: tb/tb_isolde_xif_result_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_isolde_xif_result_arbiter
//  Description : Self-checking bench for isolde_xif_result_arbiter with
//                directed scenarios and a randomized protocol-correct
//                coprocessor population checked against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_isolde_xif_result_arbiter;
    import isolde_xif_pkg::*;

    localparam int N     = 4;
    localparam int RES_W = $bits(x_result_t);
    localparam int SRC_W = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N-1:0]            vld;
    logic [N-1:0]            rdy;
    logic [N-1:0][RES_W-1:0] pay;
    logic                    cpu_valid;
    logic                    cpu_rdy;
    logic [RES_W-1:0]        cpu_res;
    logic [SRC_W-1:0]        cpu_src;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic             m_valid;
    logic [RES_W-1:0] m_res;
    int               m_src;
    int               m_ptr;
    int               last_hs;

    always #5 clk = ~clk;

    isolde_xif_result_arbiter #(
        .N_COPROC    (N),
        .X_ID_WIDTH  (4),
        .X_RFW_WIDTH (32)
    ) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .coproc_result_valid_i (vld),
        .coproc_result_ready_o (rdy),
        .coproc_result_i       (pay),
        .cpu_result_valid_o    (cpu_valid),
        .cpu_result_ready_i    (cpu_rdy),
        .cpu_result_o          (cpu_res),
        .cpu_result_src_o      (cpu_src)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Winner = requester nearest to the pointer going upward, circularly.
    function automatic int exp_grant();
        for (int k = 0; k < N; k++) begin
            if (vld[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // Inputs are set at the negedge before calling; checks ready, clocks,
    // updates the model and checks the registered outputs.
    task automatic tick();
        int           g;
        logic [N-1:0] er;
        #1;
        g  = exp_grant();
        er = '0;
        if (!rst && (!m_valid || cpu_rdy) && g >= 0) er[g] = 1'b1;
        chk("ready", 64'(rdy), 64'(er));
        last_hs = (er != '0) ? g : -1;
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_res = '0; m_src = 0; m_ptr = 0;
        end else if (last_hs >= 0) begin
            m_valid = 1'b1; m_res = pay[last_hs]; m_src = last_hs;
            m_ptr   = (last_hs + 1) % N;
        end else if (cpu_rdy) begin
            m_valid = 1'b0;
        end
        #1;
        chk("cpu_valid", 64'(cpu_valid), 64'(m_valid));
        chk("cpu_src",   64'(cpu_src),   64'(m_src));
        chk("cpu_res",   64'(cpu_res),   64'(m_res));
        @(negedge clk);
    endtask

    initial begin
        x_result_t    r;
        logic [63:0]  rnd;

        m_valid = 1'b0; m_res = '0; m_src = 0; m_ptr = 0; last_hs = -1;
        rst = 1'b1; vld = '1; cpu_rdy = 1'b1;
        for (int i = 0; i < N; i++) pay[i] = RES_W'(64'h1111_0000_0000_0000 * (i + 1) + i);
        @(negedge clk);

        // Reset held with every requester valid
        tick(); tick();
        chk("rst_ready", 64'(rdy), 64'(0));
        chk("rst_valid", 64'(cpu_valid), 64'(0));

        // Release: all valid, full load gives 0,1,2,3,0,1,2,3 without bubbles
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("full_src",   64'(cpu_src),   64'(k % N));
            chk("full_valid", 64'(cpu_valid), 64'(1));
        end

        // Single requester 2 with a known payload
        rst = 1'b1; tick(); rst = 1'b0;
        r = '0; r.id = 4'd5; r.data = 32'hDEADBEEF;
        pay[2] = r; vld = 4'b0100; cpu_rdy = 1'b1;
        #1 chk("single_ready", 64'(rdy), 64'(4'b0100));
        tick();
        r = x_result_t'(cpu_res);
        chk("single_valid", 64'(cpu_valid), 64'(1));
        chk("single_id",    64'(r.id),      64'(5));
        chk("single_data",  64'(r.data),    64'h0000_0000_DEAD_BEEF);
        chk("single_src",   64'(cpu_src),   64'(2));
        // Pointer now 3: all valid grants 3, then wraps to 0
        vld = '1;
        tick(); chk("ptr3_src", 64'(cpu_src), 64'(3));
        tick(); chk("wrap_src", 64'(cpu_src), 64'(0));

        // Backpressure: slot holds src 1, pointer 2, requesters 0 and 3
        rst = 1'b1; tick(); rst = 1'b0;
        vld = 4'b0010; tick();
        vld = 4'b1001; cpu_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_ready", 64'(rdy), 64'(0));
            tick();
            chk("bp_src",   64'(cpu_src),   64'(1));
            chk("bp_valid", 64'(cpu_valid), 64'(1));
        end
        cpu_rdy = 1'b1;
        #1 chk("bp_release_ready", 64'(rdy), 64'(4'b1000));
        tick();
        chk("bp_reload_src",   64'(cpu_src),   64'(3));
        chk("bp_reload_valid", 64'(cpu_valid), 64'(1));

        // Reset mid-operation with a stalled full slot drops the result
        cpu_rdy = 1'b0; rst = 1'b1; tick();
        chk("midrst_valid", 64'(cpu_valid), 64'(0));
        rst = 1'b0; vld = '1; cpu_rdy = 1'b1; tick();
        chk("midrst_src", 64'(cpu_src), 64'(0));

        // Randomized traffic; coprocessors hold valid and payload until ready
        vld = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!vld[i] && $urandom_range(0, 1) == 1) begin
                    vld[i] = 1'b1;
                    rnd    = {$urandom, $urandom};
                    pay[i] = rnd[RES_W-1:0];
                end
            end
            cpu_rdy = ($urandom_range(0, 3) != 0);
            rst     = ($urandom_range(0, 63) == 0);
            tick();
            if (last_hs >= 0) vld[last_hs] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/isolde_xif_result_arbiter.md
Name: isolde_xif_result_arbiter

Overview:
Round-robin arbiter that shares the single CPU-side XIF result channel among N_COPROC coprocessors. Each coprocessor presents a result with a valid/ready handshake. The arbiter grants one requester per cycle into a one-entry output register, which drives the CPU result port with 1-cycle latency and full throughput. It sits between the coprocessor result modports and the core's cpu_result modport.

Parameters:
N_COPROC, 4, number of coprocessor result requesters (>=1, any value, need not be a power of two)
X_ID_WIDTH, 4, width of result id field
X_RFW_WIDTH, 32, register-file write width; we field width = X_RFW_WIDTH/32

Ports:
clk_i  input  1  clock
rst_i  input  1  reset; synchronous, active-high
coproc_result_valid_i  input  N_COPROC  per-coprocessor result valid
coproc_result_ready_o  output  N_COPROC  per-coprocessor result ready (one-hot or zero)
coproc_result_i  input  N_COPROC x $bits(x_result_t)  per-coprocessor result payload
cpu_result_valid_o  output  1  result valid toward CPU
cpu_result_ready_i  input  1  CPU accepts result
cpu_result_o  output  $bits(x_result_t)  registered result payload
cpu_result_src_o  output  max(1,$clog2(N_COPROC))  index of the coprocessor that produced cpu_result_o

Behaviour:
- State: out_valid_q, out_result_q, out_src_q, rr_ptr_q in [0, N_COPROC-1].
- Reset (rst_i=1 at a clock edge): out_valid_q=0, out_result_q='0, out_src_q=0, rr_ptr_q=0. While rst_i=1, coproc_result_ready_o='0 combinationally.
- A result held in the register when reset asserts is dropped.
- slot_free = !out_valid_q || cpu_result_ready_i.
- Grant selection (combinational): the first index i with valid_i[i]=1, scanning rr_ptr_q, rr_ptr_q+1, ... modulo N_COPROC. No requester means no grant.
- coproc_result_ready_o[g] = slot_free && grant_valid && !rst_i. All other bits are 0. Ready never depends on cpu_result_ready_i except through slot_free.
- On a handshake with requester g at a clock edge:
  - out_result_q <= coproc_result_i[g], out_src_q <= g, out_valid_q <= 1.
  - rr_ptr_q <= (g == N_COPROC-1) ? 0 : g+1, explicit wrap with no modulo-of-power-of-two shortcut.
- CPU drains the register (out_valid_q && cpu_result_ready_i) and no new grant: out_valid_q <= 0. Payload holds its last value.
- Drain and new grant in the same cycle: the register reloads and out_valid_q stays 1. This gives one result per cycle back-to-back.
- Backpressure (out_valid_q=1, cpu_result_ready_i=0): out_result_q, out_src_q and rr_ptr_q are stable. All coproc ready bits are 0.
- Latency: a coprocessor handshake in cycle t appears on cpu_result_valid_o in cycle t+1.
- rr_ptr_q changes only on a handshake. An idle cycle does not advance it.
- Fairness: with all requesters continuously valid, each is granted exactly once every N_COPROC grants.
- N_COPROC=1: rr_ptr_q is constant 0 and cpu_result_src_o is constant 0. The block degenerates to a pipeline register.
- Coprocessors must keep valid and payload stable until ready. The arbiter does not check this.
- Outputs cpu_result_valid_o, cpu_result_o and cpu_result_src_o come directly from flops, with no combinational input-to-output path on them.

Decomposition:
- Package isolde_xif_pkg holds:
  - the x_result_t typedef, with the same field order as the interface's result struct: id, data, rd, we, ecsdata, ecswe, exc, exccode, err, dbg, parameterised through X_ID_WIDTH and X_RFW_WIDTH;
  - localparam XLEN=32.
- One sub-module, isolde_rr_arbiter (parameter N), is combinational:
  - inputs: req vector, ptr;
  - outputs: grant_valid, grant index.
  - It is reusable for a future issue-channel dispatcher.
- The output register and pointer update live in the top module.

Test Plan:
- Reset: hold rst_i=1 with all valid_i=1 -> coproc_result_ready_o=0000, cpu_result_valid_o=0. Release rst_i -> first grant goes to index 0.
- Single requester: coproc 2 valid, id=5, data=0xDEADBEEF, cpu ready=1 -> ready_o=0100 in cycle t. In t+1: cpu_result_valid_o=1, id=5, data=0xDEADBEEF, src=2, rr_ptr=3.
- Full load: all 4 valid for 8 cycles, cpu ready=1 -> src sequence 0,1,2,3,0,1,2,3 on consecutive cycles, with no bubbles.
- Backpressure: slot full with src=1, cpu ready=0 for 3 cycles, coproc 0 and 3 valid -> output stable, ready_o=0000. Then ready=1 -> same-cycle reload from coproc 2/3 per pointer (ptr=2, so 3 is granted), with no bubble.
- Wrap with N_COPROC=3: grants to index 2 -> rr_ptr=0. Coproc 0 and 1 valid -> 0 is granted next.
- Reset mid-operation: slot full, cpu ready=0, assert rst_i one cycle -> cpu_result_valid_o=0 next cycle, result lost, rr_ptr=0.
